// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte-write master.
// This covers the state enum, the default responder address and the per-quarter bus encodings.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ACK1,
        WADDR,
        ACK2,
        DATA,
        ACK3,
        STOP
    } state_e;

    localparam logic [6:0] I2C_DEFAULT_DEV_ADDR = 7'h2E;
    localparam int         I2C_SYMBOLS          = 29;

    // Bit n of each mask is the line level during quarter qn (1 = high/released).
    localparam logic [3:0] START_SCL = 4'b0011;
    localparam logic [3:0] START_SDA = 4'b0001;
    localparam logic [3:0] STOP_SCL  = 4'b1110;
    localparam logic [3:0] STOP_SDA  = 4'b1100;
    localparam logic [3:0] BIT_SCL   = 4'b0110;

    function automatic logic [1:0] bus_levels(state_e st, logic [1:0] q, logic bit_val);
        logic [1:0] lv;
        case (st)
            IDLE:             lv = 2'b11;
            START:            lv = {START_SCL[q], START_SDA[q]};
            STOP:             lv = {STOP_SCL[q], STOP_SDA[q]};
            ACK1, ACK2, ACK3: lv = {BIT_SCL[q], 1'b1};
            default:          lv = {BIT_SCL[q], bit_val};
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/i2c_write_master_tick_gen.sv
// Quarter-period divider: this block pulses tick on the last clk of every CLK_DIV-cycle quarter.
// It also flags the clk before that. Hold freezes the terminal count so that a stretched SCL lengthens the quarter.
module i2c_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic hold,
    output logic tick,
    output logic pre_tick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] PRE  = 16'(CLK_DIV - 2);

    logic [15:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            if (!hold) begin
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = en && (cnt_q == LAST) && !hold;
    assign pre_tick = en && (cnt_q == PRE);

endmodule

// File: rtl/i2c_write_master.sv
// Single-master I2C byte write: START, {DEV_ADDR,0}, word address, data, STOP, with an ACK check after each byte.
// Define I2C_STRETCH_EN for open-drain SCL with responder clock stretching; otherwise SCL is driven push-pull.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter logic [6:0] DEV_ADDR = I2C_DEFAULT_DEV_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] word_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        scl,
    inout  wire        sda
);

    state_e      state_q, state_d;
    logic [1:0]  quarter_q, quarter_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic        sda_s1_q, sda_s2_q;
    logic        tick, pre_tick, hold;

`ifdef I2C_STRETCH_EN
    logic        scl_s1_q, scl_s2_q;

    // Only the terminal count waits, so the synchronizer lag after releasing SCL costs nothing.
    assign hold = scl_q && !scl_s2_q && (quarter_q == 2'd1 || quarter_q == 2'd2);
    assign scl  = scl_q ? 1'bz : 1'b0;
`else
    assign hold = 1'b0;
    assign scl  = scl_q;
`endif
    assign sda  = sda_q ? 1'bz : 1'b0;

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (busy_q),
        .hold     (hold),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        state_d   = state_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;

        if (state_q == IDLE) begin
            if (start) begin
                state_d   = START;
                quarter_d = 2'd0;
                bit_d     = 3'd7;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                waddr_d   = word_addr;
                wdata_d   = wr_data;
            end
        end else begin
            // done leads the final STOP tick by one clk so that busy drops right after it.
            if (state_q == STOP && quarter_q == 2'd3 && pre_tick) begin
                done_d = 1'b1;
            end
            if (tick) begin
                quarter_d = quarter_q + 2'd1;
                if ((state_q == ACK1 || state_q == ACK2 || state_q == ACK3) &&
                    quarter_q == 2'd2 && sda_s2_q) begin
                    ack_err_d = 1'b1;
                end
                if (quarter_q == 2'd3) begin
                    case (state_q)
                        START: begin
                            state_d = ADDR;
                            shift_d = {DEV_ADDR, 1'b0};
                            bit_d   = 3'd7;
                        end
                        ADDR, WADDR, DATA: begin
                            if (bit_q == 3'd0) begin
                                state_d = (state_q == ADDR)  ? ACK1 :
                                          (state_q == WADDR) ? ACK2 : ACK3;
                            end else begin
                                bit_d   = bit_q - 3'd1;
                                shift_d = {shift_q[6:0], 1'b0};
                            end
                        end
                        ACK1: begin
                            state_d = ack_err_q ? STOP : WADDR;
                            shift_d = waddr_q;
                            bit_d   = 3'd7;
                        end
                        ACK2: begin
                            state_d = ack_err_q ? STOP : DATA;
                            shift_d = wdata_q;
                            bit_d   = 3'd7;
                        end
                        ACK3: begin
                            state_d = STOP;
                        end
                        default: begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    endcase
                end
            end
        end

        {scl_d, sda_d} = bus_levels(state_d, quarter_d, shift_d[7]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the latched operands are reset as well; they are plain flops, not a memory, and this keeps them X-free.
            state_q   <= IDLE;
            quarter_q <= 2'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            waddr_q   <= 8'h00;
            wdata_q   <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
`ifdef I2C_STRETCH_EN
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            sda_s1_q  <= sda;
            sda_s2_q  <= sda_s1_q;
`ifdef I2C_STRETCH_EN
            scl_s1_q  <= scl;
            scl_s2_q  <= scl_s1_q;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: a bus decoder and an EEPROM responder model sit on the wires.
// Expected results are queued at accept and checked by a separate monitor on each done pulse.
module tb_i2c_write_master;
    import i2c_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int FULL_CYC = I2C_SYMBOLS * 4 * CLK_DIV;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] word_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    wire        scl;
    wire        sda;

    i2c_write_master #(
        .CLK_DIV  (CLK_DIV),
        .DEV_ADDR (7'h2E)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .word_addr (word_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .scl       (scl),
        .sda       (sda)
    );

    logic slv_sda_low = 1'b0;
    pullup (sda);
    assign sda = slv_sda_low ? 1'b0 : 1'bz;
`ifdef I2C_STRETCH_EN
    logic slv_scl_low = 1'b0;
    pullup (scl);
    assign scl = slv_scl_low ? 1'b0 : 1'bz;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Bus decoder: collects bytes between START and STOP and counts SCL rising edges.
    logic        in_frame = 1'b0;
    int          bit_n    = 0;
    int          rises    = 0;
    int          nbytes   = 0;
    logic [7:0]  sh       = 8'h00;
    logic [23:0] bytes    = 24'h0;
    int          f_rises  = 0;
    int          f_nbytes = 0;
    logic [23:0] f_bytes  = 24'h0;
    int          nack_byte = 0;

    initial forever begin
        @(negedge sda);
        if (scl === 1'b1) begin
            in_frame = 1'b1;
            bit_n    = 0;
            rises    = 0;
            nbytes   = 0;
            bytes    = 24'h0;
        end
    end

    initial forever begin
        @(posedge sda);
        if (scl === 1'b1 && in_frame) begin
            in_frame = 1'b0;
            f_rises  = rises;
            f_nbytes = nbytes;
            f_bytes  = bytes;
        end
    end

    initial forever begin
        @(posedge scl);
        if (in_frame) begin
            rises++;
            if (bit_n < 8) begin
                sh = {sh[6:0], sda};
                bit_n++;
            end else begin
                if (nbytes < 3) bytes[23 - 8*nbytes -: 8] = sh;
                nbytes++;
                bit_n = 0;
            end
        end
    end

    // Responder: acknowledges each byte unless nack_byte names it (1 = address byte).
    initial forever begin
        @(negedge scl);
        if (in_frame) begin
            if (bit_n == 8) slv_sda_low = (nack_byte != nbytes + 1);
            else            slv_sda_low = 1'b0;
        end
    end

    typedef struct {
        int          acc;
        int          lat;
        logic        err;
        int          nbytes;
        logic [23:0] bytes;
        int          rises;
    } exp_t;

    exp_t sb_q[$];

    initial begin : monitor
        exp_t e;
        logic chk_busy_next;
        chk_busy_next = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_busy_next) begin
                check("busy_after_done", busy, 1'b0);
                chk_busy_next = 1'b0;
            end
            if (done) begin
                check("pending_on_done", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("done_cycle", cyc_cnt - e.acc, e.lat);
                    check("ack_err", ack_err, e.err);
                    check("bytes_seen", f_nbytes, e.nbytes);
                    check("byte_values", f_bytes, e.bytes);
                    check("scl_pulses", f_rises, e.rises);
                    check("busy_at_done", busy, 1'b1);
                end
                chk_busy_next = 1'b1;
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
    task automatic issue(input logic [7:0] wa, input logic [7:0] wd, input int nack,
                         input int lat, input logic err, input int nb,
                         input logic [23:0] bexp, input int rz, input bit push,
                         output int acc);
        exp_t e;
        check("idle_before_accept", busy, 1'b0);
        word_addr = wa;
        wr_data   = wd;
        nack_byte = nack;
        start     = 1'b1;
        acc       = cyc_cnt;
        if (push) begin
            e.acc    = acc;
            e.lat    = lat;
            e.err    = err;
            e.nbytes = nb;
            e.bytes  = bexp;
            e.rises  = rz;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start     = 1'b0;
        word_addr = ~wa;
        wr_data   = ~wd;
        check("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, n < 2000, 1'b1);
    endtask

    initial begin : stim
        int acc;
        int n;
        reset     = 1'b0;
        start     = 1'b0;
        word_addr = 8'h00;
        wr_data   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda, 1'b1);
        reset = 1'b1;
        @(negedge clk);

        issue(8'h05, 8'hA5, 0, FULL_CYC, 1'b0, 3, 24'h5C05A5, 28, 1'b1, acc);
        wait_idle("t1_complete");

        issue(8'h11, 8'h22, 1, 176, 1'b1, 1, 24'h5C0000, 10, 1'b1, acc);
        wait_idle("t2_complete");
        repeat (5) @(negedge clk);
        check("ack_err_holds", ack_err, 1'b1);
        check("no_scl_after_nack", scl, 1'b1);

        issue(8'h3C, 8'h81, 2, 320, 1'b1, 2, 24'h5C3C00, 19, 1'b1, acc);
        wait_idle("t3_complete");

        issue(8'hFF, 8'h00, 3, FULL_CYC, 1'b1, 3, 24'h5CFF00, 28, 1'b1, acc);
        wait_idle("t4_complete");

        issue(8'h80, 8'h7E, 0, FULL_CYC, 1'b0, 3, 24'h5C807E, 28, 1'b1, acc);
        check("ack_err_cleared_at_accept", ack_err, 1'b0);
        while (cyc_cnt < acc + 100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t5_complete");
        repeat (20) @(negedge clk);
        check("no_second_txn", busy, 1'b0);

        issue(8'h5A, 8'hC3, 0, FULL_CYC, 1'b0, 3, 24'h5C5AC3, 28, 1'b1, acc);
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t6_done_seen", done, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_at_done_ignored", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("stays_idle", busy, 1'b0);

        issue(8'h05, 8'hA5, 0, 0, 1'b0, 0, 24'h0, 0, 1'b0, acc);
        while (cyc_cnt < acc + 200) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_scl", scl, 1'b1);
        check("abort_sda", sda, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        issue(8'h42, 8'h99, 0, FULL_CYC, 1'b0, 3, 24'h5C4299, 28, 1'b1, acc);
        wait_idle("t7_complete");

`ifdef I2C_STRETCH_EN
        issue(8'h05, 8'hA5, 0, FULL_CYC + 20, 1'b0, 3, 24'h5C05A5, 28, 1'b1, acc);
        while (cyc_cnt < acc + 148) @(negedge clk);
        slv_scl_low = 1'b1;
        while (cyc_cnt < acc + 170) @(negedge clk);
        slv_scl_low = 1'b0;
        wait_idle("t8_complete");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
